// File: rtl/micro_pkg.sv
// Shared types and microinstruction field layout for the micro-sequencer.
// The layout from MSB to LSB is: next_addr, seq_op, cond_sel, cond_pol, ctrl.
package micro_pkg;

  typedef enum logic [1:0] {
    SEQ_JUMP     = 2'b00,
    SEQ_DISPATCH = 2'b01,
    SEQ_COND     = 2'b10,
    SEQ_HALT     = 2'b11
  } seq_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RUN  = 2'b10,
    ST_HALT = 2'b11
  } state_e;

  // A single flag still needs a 1-bit select field.
  function automatic int sel_width(input int nflags);
    return (nflags > 1) ? $clog2(nflags) : 1;
  endfunction

  function automatic int mir_width(input int addr_w, input int sel_w, input int ctrl_w);
    return addr_w + 2 + sel_w + 1 + ctrl_w;
  endfunction

  function automatic int pol_lsb(input int ctrl_w);
    return ctrl_w;
  endfunction

  function automatic int sel_lsb(input int ctrl_w);
    return ctrl_w + 1;
  endfunction

  function automatic int op_lsb(input int sel_w, input int ctrl_w);
    return ctrl_w + 1 + sel_w;
  endfunction

  function automatic int next_lsb(input int sel_w, input int ctrl_w);
    return ctrl_w + 3 + sel_w;
  endfunction

endpackage

// File: rtl/micro_store.sv
// Control store: one write port, one synchronous read port whose output
// register doubles as the microinstruction register (clear and hold controls).
module micro_store #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 31
) (
  input  logic              clk,
  input  logic              rd_en,
  input  logic              rd_clr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] mem_r [2**ADDR_W];

  // Write port; contents survive reset by design
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Read-first output register: a same-cycle write to rd_addr is not visible yet
  always_ff @(posedge clk) begin
    if (rd_clr) begin
      rd_data <= {DATA_W{1'b0}};
    end else if (rd_en) begin
      rd_data <= mem_r[rd_addr];
    end
  end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: start delay, next-address selection (jump, dispatch,
// conditional, halt) and fetch from the control store into mir.
module micro_sequencer
  import micro_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int NFLAGS      = 4,
  parameter int CTRL_W      = 18,
  parameter int START_DELAY = 3,
  parameter int RESET_VEC   = 0,
  localparam int SEL_W      = sel_width(NFLAGS),
  localparam int MIR_W      = mir_width(ADDR_W, SEL_W, CTRL_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              stall,
  input  logic [NFLAGS-1:0] flags,
  input  logic [ADDR_W-1:0] dispatch_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [MIR_W-1:0]  wr_data,
  output logic [MIR_W-1:0]  mir,
  output logic [ADDR_W-1:0] upc,
  output logic              running,
  output logic              halted
);

  localparam int CNT_W    = $clog2(START_DELAY + 2);
  localparam int NEXT_LSB = next_lsb(SEL_W, CTRL_W);
  localparam int OP_LSB   = op_lsb(SEL_W, CTRL_W);
  localparam int SEL_LSB  = sel_lsb(CTRL_W);
  localparam int POL_LSB  = pol_lsb(CTRL_W);
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  // START_DELAY of 0 and 1 both fetch in the first WAIT cycle.
  localparam logic [CNT_W-1:0]  CNT_INIT = (START_DELAY > 0) ? CNT_W'(START_DELAY - 1) : CNT_ZERO;
  localparam logic [ADDR_W-1:0] VEC      = ADDR_W'(RESET_VEC);

  state_e            state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              enable_prev_r;
  logic [ADDR_W-1:0] upc_r;
  logic              running_r;
  logic              halted_r;

  logic [ADDR_W-1:0] next_addr_s;
  seq_op_e           seq_op_s;
  logic [SEL_W-1:0]  cond_sel_s;
  logic              cond_pol_s;
  logic              cond_hit_s;
  logic [ADDR_W-1:0] next_s;
  logic              enable_rise_s;
  logic              fetch_s;
  logic [ADDR_W-1:0] fetch_addr_s;

  assign next_addr_s   = mir[NEXT_LSB +: ADDR_W];
  assign seq_op_s      = seq_op_e'(mir[OP_LSB +: 2]);
  assign cond_sel_s    = mir[SEL_LSB +: SEL_W];
  assign cond_pol_s    = mir[POL_LSB];
  assign enable_rise_s = enable & ~enable_prev_r;

  // Condition test; selects beyond the flag vector read as 0
  always_comb begin
    if (int'(cond_sel_s) < NFLAGS) begin
      cond_hit_s = (flags[cond_sel_s] == cond_pol_s);
    end else begin
      cond_hit_s = (cond_pol_s == 1'b0);
    end
  end

  // Next micro-address from the word currently in mir
  always_comb begin
    case (seq_op_s)
      SEQ_JUMP:     next_s = next_addr_s;
      SEQ_DISPATCH: next_s = dispatch_addr;
      SEQ_COND:     next_s = cond_hit_s ? next_addr_s : upc_r + ADDR_W'(1);
      SEQ_HALT:     next_s = upc_r;
      default:      next_s = upc_r;
    endcase
  end

  // Store read request: start vector after the delay, otherwise the next address
  always_comb begin
    fetch_s      = 1'b0;
    fetch_addr_s = next_s;
    if (reset) begin
      fetch_s = 1'b0;
    end else if (state_r == ST_WAIT && cnt_r == CNT_ZERO) begin
      fetch_s      = 1'b1;
      fetch_addr_s = VEC;
    end else if (state_r == ST_RUN && !stall && seq_op_s != SEQ_HALT) begin
      fetch_s = 1'b1;
    end else begin
      fetch_s = 1'b0;
    end
  end

  // Sequencer FSM with registered micro-PC and status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      cnt_r         <= CNT_ZERO;
      enable_prev_r <= 1'b0;
      upc_r         <= {ADDR_W{1'b0}};
      running_r     <= 1'b0;
      halted_r      <= 1'b0;
    end else begin
      enable_prev_r <= enable;
      case (state_r)
        ST_IDLE: begin
          if (enable_rise_s) begin
            state_r <= ST_WAIT;
            cnt_r   <= CNT_INIT;
          end
        end
        ST_WAIT: begin
          if (cnt_r == CNT_ZERO) begin
            state_r   <= ST_RUN;
            upc_r     <= VEC;
            running_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (!stall) begin
            if (seq_op_s == SEQ_HALT) begin
              state_r   <= ST_HALT;
              running_r <= 1'b0;
              halted_r  <= 1'b1;
            end else begin
              upc_r <= next_s;
            end
          end
        end
        ST_HALT: begin
          if (enable_rise_s) begin
            state_r  <= ST_WAIT;
            cnt_r    <= CNT_INIT;
            halted_r <= 1'b0;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  micro_store #(
    .ADDR_W(ADDR_W),
    .DATA_W(MIR_W)
  ) u_store (
    .clk    (clk),
    .rd_en  (fetch_s),
    .rd_clr (reset),
    .rd_addr(fetch_addr_s),
    .rd_data(mir),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data)
  );

  assign upc     = upc_r;
  assign running = running_r;
  assign halted  = halted_r;

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer at default parameters: directed
// scenarios plus a randomized run against a cycle-level reference model.
module tb_micro_sequencer;

  localparam int START_DELAY = 3;
  localparam int RESET_VEC   = 0;
  localparam int P_IDLE = 0, P_WAIT = 1, P_RUN = 2, P_HALT = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        stall = 1'b0;
  logic [3:0]  flags = 4'h0;
  logic [7:0]  dispatch_addr = 8'h00;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_addr = 8'h00;
  logic [30:0] wr_data = 31'h0;
  logic [30:0] mir;
  logic [7:0]  upc;
  logic        running;
  logic        halted;

  int n_checks = 0;
  int n_fails  = 0;

  // reference model state
  int          m_ph = P_IDLE;
  int          m_cnt = 0;
  bit          m_prev = 1'b0;
  logic [7:0]  m_upc = 8'h00;
  logic [30:0] m_mir = 31'h0;
  logic [30:0] mem [256];

  micro_sequencer dut (
    .clk(clk), .reset(reset), .enable(enable), .stall(stall), .flags(flags),
    .dispatch_addr(dispatch_addr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .mir(mir), .upc(upc), .running(running), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [30:0] mk(input logic [7:0] nx, input logic [1:0] op,
                                     input logic [1:0] sel, input logic pol);
    return {nx, op, sel, pol, 18'h2A5A5};
  endfunction

  localparam logic [30:0] W00 = {8'h05, 2'd0, 2'd0, 1'b0, 18'h2A5A5};
  localparam logic [30:0] W05 = {8'h20, 2'd2, 2'd0, 1'b1, 18'h2A5A5};
  localparam logic [30:0] W06 = {8'h40, 2'd0, 2'd0, 1'b0, 18'h2A5A5};
  localparam logic [30:0] W20 = {8'h05, 2'd0, 2'd0, 1'b0, 18'h2A5A5};
  localparam logic [30:0] W40 = {8'h00, 2'd1, 2'd0, 1'b0, 18'h2A5A5};
  localparam logic [30:0] W3A = {8'hFF, 2'd0, 2'd0, 1'b0, 18'h2A5A5};
  localparam logic [30:0] WFF = {8'h10, 2'd2, 2'd2, 1'b1, 18'h2A5A5};
  localparam logic [30:0] W70 = {8'h00, 2'd3, 2'd0, 1'b0, 18'h2A5A5};

  // Advance one clock, updating the model from the inputs the DUT samples.
  task automatic tick();
    int op, sel, nxt;
    bit rise, fbit, pol;
    rise = enable && !m_prev;
    if (reset) begin
      m_ph = P_IDLE; m_cnt = 0; m_prev = 1'b0; m_upc = 8'h00; m_mir = 31'h0;
    end else begin
      if (m_ph == P_IDLE) begin
        if (rise) begin m_ph = P_WAIT; m_cnt = (START_DELAY > 0) ? START_DELAY - 1 : 0; end
      end else if (m_ph == P_WAIT) begin
        if (m_cnt == 0) begin m_ph = P_RUN; m_upc = RESET_VEC; m_mir = mem[RESET_VEC]; end
        else m_cnt = m_cnt - 1;
      end else if (m_ph == P_RUN) begin
        if (!stall) begin
          op  = int'(m_mir >> 21) & 3;
          sel = int'(m_mir >> 19) & 3;
          pol = m_mir[18];
          if (op == 3) begin
            m_ph = P_HALT;
          end else begin
            if (op == 0) nxt = int'(m_mir >> 23);
            else if (op == 1) nxt = int'(dispatch_addr);
            else begin
              fbit = (sel < 4) ? flags[sel] : 1'b0;
              nxt = (fbit == pol) ? int'(m_mir >> 23) : (int'(m_upc) + 1) % 256;
            end
            m_upc = nxt[7:0];
            m_mir = mem[nxt];
          end
        end
      end else begin
        if (rise) begin m_ph = P_WAIT; m_cnt = (START_DELAY > 0) ? START_DELAY - 1 : 0; end
      end
      m_prev = enable;
    end
    if (wr_en) mem[wr_addr] = wr_data;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [30:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; stall = 1'b1;
    for (int i = 0; i < 256; i++) load(i[7:0], 31'($urandom));
    load(8'h00, W00); load(8'h05, W05); load(8'h06, W06); load(8'h20, W20);
    load(8'h40, W40); load(8'h3A, W3A); load(8'hFF, WFF); load(8'h70, W70);
    enable = 1'b0; stall = 1'b0;
    tick();
    n_checks++;
    if (mir !== 31'h0 || upc !== 8'h00 || running !== 1'b0 || halted !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_state: mir=%h upc=%h run=%b halt=%b, required 0/0/0/0", mir, upc, running, halted);
    end
  endtask

  task automatic test_start();
    reset = 1'b1; tick();
    reset = 1'b0; tick();
    enable = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_checks++;
      if (running !== (i == 4)) begin
        n_fails++;
        $display("FAIL start_delay cycle %0d: running=%b required %b", i, running, (i == 4));
      end
    end
    n_checks++;
    if (upc !== 8'h00 || mir !== W00) begin
      n_fails++;
      $display("FAIL start_fetch: upc=%h mir=%h, required 00 %h", upc, mir, W00);
    end
  endtask

  task automatic test_cond();
    tick();
    n_checks++;
    if (upc !== 8'h05 || mir !== W05) begin
      n_fails++; $display("FAIL jump: upc=%h mir=%h, required 05 %h", upc, mir, W05);
    end
    flags = 4'b0001; tick();
    n_checks++;
    if (upc !== 8'h20 || mir !== W20) begin
      n_fails++; $display("FAIL cond_taken: upc=%h mir=%h, required 20 %h", upc, mir, W20);
    end
    tick();
    flags = 4'b0000; tick();
    n_checks++;
    if (upc !== 8'h06 || mir !== W06) begin
      n_fails++; $display("FAIL cond_not_taken: upc=%h mir=%h, required 06 %h", upc, mir, W06);
    end
  endtask

  task automatic test_dispatch_stall();
    tick();
    dispatch_addr = 8'h3A; tick();
    n_checks++;
    if (upc !== 8'h3A || mir !== W3A) begin
      n_fails++; $display("FAIL dispatch: upc=%h mir=%h, required 3a %h", upc, mir, W3A);
    end
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      flags = 4'($urandom); dispatch_addr = 8'($urandom);
      tick();
      n_checks++;
      if (upc !== 8'h3A || mir !== W3A || running !== 1'b1) begin
        n_fails++; $display("FAIL stall_hold %0d: upc=%h mir=%h run=%b, required 3a %h 1", i, upc, mir, running, W3A);
      end
    end
    stall = 1'b0; flags = 4'h0; tick();
    n_checks++;
    if (upc !== 8'hFF || mir !== WFF) begin
      n_fails++; $display("FAIL stall_resume: upc=%h mir=%h, required ff %h", upc, mir, WFF);
    end
  endtask

  task automatic test_wrap();
    flags = 4'h0; tick();
    n_checks++;
    if (upc !== 8'h00 || mir !== W00) begin
      n_fails++; $display("FAIL upc_wrap: upc=%h mir=%h, required 00 %h", upc, mir, W00);
    end
  endtask

  task automatic test_halt();
    tick(); tick(); tick();
    dispatch_addr = 8'h70; tick();
    n_checks++;
    if (upc !== 8'h70 || mir !== W70 || halted !== 1'b0) begin
      n_fails++; $display("FAIL halt_fetch: upc=%h mir=%h halt=%b, required 70 %h 0", upc, mir, halted, W70);
    end
    for (int i = 0; i < 11; i++) begin
      flags = 4'($urandom); dispatch_addr = 8'($urandom);
      tick();
      n_checks++;
      if (halted !== 1'b1 || running !== 1'b0 || mir !== W70 || upc !== 8'h70) begin
        n_fails++; $display("FAIL halt_hold %0d: halt=%b run=%b upc=%h mir=%h, required 1 0 70 %h", i, halted, running, upc, mir, W70);
      end
    end
    enable = 1'b0; tick();
    enable = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_checks++;
      if (running !== (i == 4) || halted !== 1'b0) begin
        n_fails++; $display("FAIL restart cycle %0d: run=%b halt=%b, required %b 0", i, running, halted, (i == 4));
      end
    end
    n_checks++;
    if (upc !== 8'h00 || mir !== W00) begin
      n_fails++; $display("FAIL restart_vec: upc=%h mir=%h, required 00 %h", upc, mir, W00);
    end
  endtask

  task automatic test_write_collision();
    flags = 4'h0;
    wr_en = 1'b1; wr_addr = 8'h05; wr_data = 31'h1234;
    tick();
    wr_en = 1'b0;
    n_checks++;
    if (upc !== 8'h05 || mir !== W05) begin
      n_fails++; $display("FAIL read_first: upc=%h mir=%h, required 05 %h", upc, mir, W05);
    end
    tick(); tick();
    dispatch_addr = 8'h00; tick(); tick();
    n_checks++;
    if (upc !== 8'h05 || mir !== 31'h1234) begin
      n_fails++; $display("FAIL new_word: upc=%h mir=%h, required 05 00001234", upc, mir);
    end
    tick();
    enable = 1'b0; reset = 1'b1; tick();
    reset = 1'b0;
    n_checks++;
    if (mir !== 31'h0 || upc !== 8'h00 || running !== 1'b0 || halted !== 1'b0) begin
      n_fails++; $display("FAIL mid_run_reset: mir=%h upc=%h run=%b halt=%b, required 0/0/0/0", mir, upc, running, halted);
    end
    for (int i = 0; i < 5; i++) tick();
    n_checks++;
    if (running !== 1'b0 || mir !== 31'h0) begin
      n_fails++; $display("FAIL idle_after_reset: run=%b mir=%h, required 0 0", running, mir);
    end
    enable = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    n_checks++;
    if (running !== 1'b1 || mir !== W00) begin
      n_fails++; $display("FAIL store_retained0: run=%b mir=%h, required 1 %h", running, mir, W00);
    end
    tick();
    n_checks++;
    if (mir !== 31'h1234) begin
      n_fails++; $display("FAIL store_retained5: mir=%h, required 00001234", mir);
    end
  endtask

  task automatic test_random();
    reset = 1'b1; enable = 1'b0; stall = 1'b0;
    for (int i = 0; i < 256; i++) load(i[7:0], 31'($urandom));
    reset = 1'b0; tick();
    for (int c = 0; c < 3000; c++) begin
      reset         = ($urandom_range(0, 199) == 0);
      stall         = ($urandom_range(0, 3) == 0);
      flags         = 4'($urandom);
      dispatch_addr = 8'($urandom);
      wr_en         = ($urandom_range(0, 7) == 0);
      wr_addr       = 8'($urandom);
      wr_data       = 31'($urandom);
      if ($urandom_range(0, 9) == 0) enable = ~enable;
      tick();
      n_checks++;
      if (mir !== m_mir || upc !== m_upc || running !== (m_ph == P_RUN) || halted !== (m_ph == P_HALT)) begin
        n_fails++;
        $display("FAIL random cycle %0d: mir=%h upc=%h run=%b halt=%b, required %h %h %b %b",
                 c, mir, upc, running, halted, m_mir, m_upc, (m_ph == P_RUN), (m_ph == P_HALT));
      end
    end
    wr_en = 1'b0; reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_start();
    test_cond();
    test_dispatch_stall();
    test_wrap();
    test_halt();
    test_write_collision();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/micro_sequencer.md
MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, micro-address width; control store depth = 2**ADDR_W.
REQ-002 SHALL have parameter NFLAGS, default 4, number of testable condition flags; SEL_W = clog2(NFLAGS).
REQ-003 SHALL have parameter CTRL_W, default 18, control-field width; MIR_W = ADDR_W+2+SEL_W+1+CTRL_W (31 at defaults).
REQ-004 SHALL have parameter START_DELAY, default 3, cycles from enable rise to first fetch.
REQ-005 SHALL have parameter RESET_VEC, default 0, first micro-address fetched after start.
REQ-006 clk  in  1  single clock, all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 enable  in  1  start request; rising edge sampled on clk.
REQ-009 stall  in  1  freezes upc and mir while high.
REQ-010 flags  in  NFLAGS  condition inputs (bit 0 = Z).
REQ-011 dispatch_addr  in  ADDR_W  opcode-derived target for DISPATCH.
REQ-012 wr_en  in  1  control-store write strobe.
REQ-013 wr_addr  in  ADDR_W  write address.
REQ-014 wr_data  in  MIR_W  write data.
REQ-015 mir  out  MIR_W  registered microinstruction.
REQ-016 upc  out  ADDR_W  address of word in mir.
REQ-017 running  out  1  high in RUN.
REQ-018 halted  out  1  high in HALT.

Function
REQ-019 mir fields, MSB first: next_addr[ADDR_W], seq_op[2], cond_sel[SEL_W], cond_pol[1], ctrl[CTRL_W].
REQ-020 States: IDLE, WAIT, RUN, HALT.
REQ-021 IDLE: mir = 0, upc = 0; enable rising edge (enable=1, previous sample 0) -> WAIT, counter = START_DELAY-1.
REQ-022 WAIT: counter decrements each cycle; at 0 -> RUN, mir <= store[RESET_VEC], upc <= RESET_VEC; START_DELAY=0 fetches in first WAIT cycle.
REQ-023 RUN, stall=0: upc <= next, mir <= store[next], next from current mir.seq_op.
REQ-024 seq_op 00 JUMP: next = next_addr.
REQ-025 seq_op 01 DISPATCH: next = dispatch_addr sampled this cycle.
REQ-026 seq_op 10 COND: next = (flags[cond_sel]==cond_pol) ? next_addr : upc+1; cond_sel >= NFLAGS tests as 0.
REQ-027 seq_op 11 HALT: state -> HALT next cycle; mir, upc hold.
REQ-028 upc+1 wraps modulo 2**ADDR_W.
REQ-029 RUN, stall=1: upc, mir, state hold; flags and dispatch_addr ignored.
REQ-030 HALT: holds mir/upc; enable rising edge -> WAIT (restart from RESET_VEC).
REQ-031 Enable edges in WAIT or RUN are ignored.
REQ-032 Control-store write occurs on any cycle in any state; read of the address being written same cycle returns old data (read-first).
REQ-033 Fetch latency: one clock from next-address decision to mir update.

Reset
REQ-034 reset=1 -> state IDLE, mir 0, upc 0, running 0, halted 0, delay counter 0, enable edge register 0; dominates stall, enable, HALT.
REQ-035 Control-store contents are not cleared by reset; a write with wr_en=1 during reset is performed.
REQ-036 Reset mid-RUN abandons current microinstruction; next fetch only after a new enable rising edge.

Structure
REQ-037 Shared package micro_pkg SHALL hold seq_op enum (JUMP, DISPATCH, COND, HALT), state enum, field-offset functions of ADDR_W/SEL_W/CTRL_W.
REQ-038 Control store SHALL be a separate sub-module micro_store (synchronous read, one write port, depth 2**ADDR_W, width MIR_W).

Verification
REQ-039 reset, enable 0->1 at cycle 0, START_DELAY=3 -> running=1 and upc=0 with mir=store[0] after cycle 3, not before.
REQ-040 store[5]=COND sel 0 pol 1 next 0x20; flags=0001 -> upc=0x20; flags=0000 -> upc=0x06.
REQ-041 DISPATCH word, dispatch_addr=0x3A -> upc=0x3A, mir=store[0x3A]; stall=1 for 4 cycles during it -> upc/mir unchanged, resume on stall drop.
REQ-042 COND fail at upc=0xFF -> upc=0x00 (wrap).
REQ-043 HALT word -> halted=1 next cycle, mir stable 10 cycles; enable re-pulse -> restart at RESET_VEC after START_DELAY.
REQ-044 write 0x1234 to address currently fetched -> old word loaded this cycle, new word on next fetch; reset asserted mid-RUN -> mir=0, IDLE, store retained.
